fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage with its IF/ID pipeline register: holds the program counter, drives the instruction-memory address, and registers the fetched word into the `instruction` input of the decode stage. LDM is a two-word instruction, so this block assembles it: it fetches the opcode word, then the immediate word, and presents both to decode in the same cycle. Decode therefore never sees the immediate word as an instruction.

## Interface
- `width`, 16 — instruction / data word width.
- `pc_width`, 16 — program counter and instruction-memory address width.
- `RESET_PC`, 0 — PC value loaded on reset.
- `LDM_OP`, 5'b10100 — opcode (bits [width-1:width-5]) marking a two-word LDM.

Ports:
- `clk`  in  1 — single clock; all state updates on its rising edge.
- `rst`  in  1 — reset, asynchronous, active-low.
- `enable`  in  1 — global run enable; low freezes all state.
- `stall`  in  1 — hazard stall from downstream; high holds PC, FSM and IF/ID register.
- `branch_taken`  in  1 — redirect request.
- `branch_addr`  in  pc_width — redirect target.
- `imem_addr`  out  pc_width — instruction-memory address, combinationally equal to PC.
- `imem_data`  in  width — instruction-memory read data, valid in the same cycle as `imem_addr`.
- `instruction`  out  width — registered instruction to decode.
- `imm`  out  width — registered immediate word; meaningful only with an LDM in `instruction`.
- `pc_out`  out  pc_width — registered address of the instruction in `instruction`.
- `valid`  out  1 — high when `instruction` holds a real instruction; low means NOP bubble.

## Operation
- State registers: `pc`, a two-state FSM {FETCH, IMM}, and `pend_instr`/`pend_pc` holding the LDM opcode word and its address.
- Priority each edge: reset > `enable`=0 (hold all) > `branch_taken` > `stall` (hold all) > normal fetch.
- FETCH, word W at `pc`, opcode ≠ LDM_OP:
  - `instruction`←W, `pc_out`←`pc`, `valid`←1, `imm` holds.
  - `pc`←`pc`+1.
  - Stay in FETCH.
- FETCH, opcode = LDM_OP:
  - `pend_instr`←W, `pend_pc`←`pc`.
  - `instruction`←16'h0000, `valid`←0 (bubble).
  - `pc`←`pc`+1; go to IMM.
- IMM:
  - `imm`←`imem_data`, `instruction`←`pend_instr`, `pc_out`←`pend_pc`, `valid`←1.
  - `pc`←`pc`+1; go to FETCH.
  - The immediate word is never decoded as an opcode.
- `branch_taken` (any state):
  - `pc`←`branch_addr`, FSM←FETCH, pending LDM discarded.
  - `instruction`←0, `valid`←0. `pc_out` and `imm` hold.
- PC arithmetic is modulo 2^pc_width. 16'hFFFF+1 wraps to 16'h0000, so an LDM at 16'hFFFF takes its immediate from 16'h0000.
- Reset values:
  - `pc`=RESET_PC, FSM=FETCH, `pend_instr`=0, `pend_pc`=0.
  - `instruction`=0, `imm`=0, `pc_out`=0, `valid`=0.
  - `imem_addr`=RESET_PC.

## Timing
- Latency: a word at `imem_addr` in cycle t appears on `instruction` after edge t (1 cycle).
- LDM: 2 cycles. Opcode fetched at t, immediate at t+1; both visible together after edge t+1, with a `valid`=0 bubble after edge t.
- `stall` or `enable`=0 for N cycles:
  - All registered outputs and `imem_addr` are stable for those N cycles.
  - Fetch resumes exactly where it stopped, including mid-LDM (IMM state kept).
- `branch_taken` together with `stall`: branch wins. `stall` must not block a redirect.
- `rst` asserted mid-LDM: all outputs return to reset values immediately, without waiting for a clock edge. The FSM restarts in FETCH at RESET_PC after `rst` deasserts.
- No combinational path from `imem_data` to any output. `imem_addr` depends only on `pc`.

## Test plan
- Reset: hold `rst`=0 with `clk` running → `instruction`=0, `valid`=0, `imem_addr`=0. Release → `imem_addr` steps 0,1,2 on successive edges.
- Sequential stream: mem[0..2]=16'h0800,16'h1100,16'h1A00 → `instruction` shows these one cycle after each address; `pc_out`=0,1,2; `valid`=1.
- LDM: mem[4]=16'hA100 (opcode 10100), mem[5]=16'h1234 → one bubble (`valid`=0), then `instruction`=16'hA100, `imm`=16'h1234, `pc_out`=4; next fetch is address 6.
- Stall mid-LDM: assert `stall` for 3 cycles while in IMM → outputs frozen, `imem_addr`=5 held; after release LDM completes with `imm`=16'h1234.
- Branch mid-LDM: `branch_taken`=1, `branch_addr`=16'h0040 while in IMM → `valid`=0, next `imem_addr`=16'h0040, and the pending A100 never reaches `instruction`.
- Wrap and enable: LDM at 16'hFFFF with mem[0]=16'h00FF → `imm`=16'h00FF, next `imem_addr`=1. Drop `enable` for 2 cycles → no output changes.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: instruction-memory port, control inputs and IF/ID outputs.
interface fetch_stage_if #(
    parameter int width    = 16,
    parameter int pc_width = 16
);
    logic                enable;
    logic                stall;
    logic                branch_taken;
    logic [pc_width-1:0] branch_addr;
    logic [pc_width-1:0] imem_addr;
    logic [width-1:0]    imem_data;
    logic [width-1:0]    instruction;
    logic [width-1:0]    imm;
    logic [pc_width-1:0] pc_out;
    logic                valid;

    modport master (
        input  enable, stall, branch_taken, branch_addr, imem_data,
        output imem_addr, instruction, imm, pc_out, valid
    );

    modport slave (
        output enable, stall, branch_taken, branch_addr, imem_data,
        input  imem_addr, instruction, imm, pc_out, valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register; assembles two-word LDM
// (opcode + immediate) so decode sees both in one cycle.
module fetch_stage #(
    parameter int                  width    = 16,
    parameter int                  pc_width = 16,
    parameter logic [pc_width-1:0] RESET_PC = '0,
    parameter logic [4:0]          LDM_OP   = 5'b10100
) (
    input logic         clk,
    input logic         rst,
    fetch_stage_if.master f
);
    typedef enum logic {FETCH, IMM} state_t;

    localparam logic [pc_width-1:0] PC_ONE = 1;

    state_t              state;
    logic [pc_width-1:0] pc;
    logic [width-1:0]    pend_instr;
    logic [pc_width-1:0] pend_pc;
    logic [width-1:0]    instr_q;
    logic [width-1:0]    imm_q;
    logic [pc_width-1:0] pc_out_q;
    logic                valid_q;

    assign f.imem_addr   = pc;
    assign f.instruction = instr_q;
    assign f.imm         = imm_q;
    assign f.pc_out      = pc_out_q;
    assign f.valid       = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pend_instr <= '0;
            pend_pc    <= '0;
            instr_q    <= '0;
            imm_q      <= '0;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
        end else if (!f.enable) begin
            state <= state;
        end else if (f.branch_taken) begin
            // Redirect drops any half-assembled LDM
            state   <= FETCH;
            pc      <= f.branch_addr;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!f.stall) begin
            pc <= pc + PC_ONE;
            unique case (state)
                FETCH: begin
                    if (f.imem_data[width-1 -: 5] == LDM_OP) begin
                        state      <= IMM;
                        pend_instr <= f.imem_data;
                        pend_pc    <= pc;
                        instr_q    <= '0;
                        valid_q    <= 1'b0;
                    end else begin
                        instr_q  <= f.imem_data;
                        pc_out_q <= pc;
                        valid_q  <= 1'b1;
                    end
                end
                IMM: begin
                    state    <= FETCH;
                    imm_q    <= f.imem_data;
                    instr_q  <= pend_instr;
                    pc_out_q <= pend_pc;
                    valid_q  <= 1'b1;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control
// inputs, checked against a queue-based fetch model.
module tb_fetch_stage;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fetch_stage_if #(.width(16), .pc_width(16)) f ();

    fetch_stage #(
        .width(16), .pc_width(16),
        .RESET_PC(16'h0000), .LDM_OP(5'b10100)
    ) dut (
        .clk(clk), .rst(rst), .f(f)
    );

    logic [15:0] mem [0:65535];
    assign f.imem_data = mem[f.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] a;
    } pend_t;

    pend_t       pend[$];
    logic [15:0] m_pc;
    logic [15:0] m_instr;
    logic [15:0] m_imm;
    logic [15:0] m_pcout;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_instr = 16'h0000;
        m_imm   = 16'h0000;
        m_pcout = 16'h0000;
        m_valid = 1'b0;
        pend.delete();
    endtask

    // One clock of fetch behaviour; a non-empty queue means an LDM
    // opcode is waiting for its immediate word.
    task automatic model_step();
        logic [15:0] w;
        if (!rst) begin
            model_reset();
        end else if (!f.enable) begin
        end else if (f.branch_taken) begin
            m_pc    = f.branch_addr;
            m_instr = 16'h0000;
            m_valid = 1'b0;
            pend.delete();
        end else if (f.stall) begin
        end else begin
            w = mem[m_pc];
            if (pend.size() != 0) begin
                m_imm   = w;
                m_instr = pend[0].w;
                m_pcout = pend[0].a;
                m_valid = 1'b1;
                pend.delete();
            end else if (w[15:11] == 5'b10100) begin
                pend.push_back('{w: w, a: m_pc});
                m_instr = 16'h0000;
                m_valid = 1'b0;
            end else begin
                m_instr = w;
                m_pcout = m_pc;
                m_valid = 1'b1;
            end
            m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".instr"}, 32'(f.instruction), 32'(m_instr));
        check({tag, ".imm"}, 32'(f.imm), 32'(m_imm));
        check({tag, ".pc_out"}, 32'(f.pc_out), 32'(m_pcout));
        check({tag, ".valid"}, 32'(f.valid), 32'(m_valid));
        check({tag, ".addr"}, 32'(f.imem_addr), 32'(m_pc));
    endtask

    // Drive inputs just after a falling edge, clock once, check at
    // the next falling edge.
    task automatic step(input logic en, input logic st,
                        input logic br, input logic [15:0] ba,
                        input string tag);
        f.enable       = en;
        f.stall        = st;
        f.branch_taken = br;
        f.branch_addr  = ba;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(3) == 0) mem[i][15:11] = 5'b10100;
        end
        mem[0]      = 16'h0800;
        mem[1]      = 16'h1100;
        mem[2]      = 16'h1A00;
        mem[3]      = 16'h0300;
        mem[4]      = 16'hA100;
        mem[5]      = 16'h1234;
        mem[6]      = 16'hA1FF;
        mem[7]      = 16'h0007;
        mem[16'h40] = 16'h0100;
        mem[16'hFFFF] = 16'hA5A5;

        rst            = 1'b0;
        f.enable       = 1'b1;
        f.stall        = 1'b0;
        f.branch_taken = 1'b0;
        f.branch_addr  = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst.instr", 32'(f.instruction), 32'h0);
        check("rst.valid", 32'(f.valid), 32'h0);
        check("rst.addr", 32'(f.imem_addr), 32'h0);
        rst = 1'b1;

        step(1, 0, 0, 0, "seq0");
        check("seq0.word", 32'(f.instruction), 32'h0800);
        check("seq0.addr1", 32'(f.imem_addr), 32'h1);
        step(1, 0, 0, 0, "seq1");
        check("seq1.word", 32'(f.instruction), 32'h1100);
        check("seq1.addr2", 32'(f.imem_addr), 32'h2);
        step(1, 0, 0, 0, "seq2");
        check("seq2.pc_out", 32'(f.pc_out), 32'h2);
        step(1, 0, 0, 0, "seq3");

        step(1, 0, 0, 0, "ldm.bubble");
        check("ldm.bubble_valid", 32'(f.valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, "ldm.stall");
            check("ldm.stall_addr", 32'(f.imem_addr), 32'h5);
        end
        step(1, 0, 0, 0, "ldm.done");
        check("ldm.instr", 32'(f.instruction), 32'hA100);
        check("ldm.imm", 32'(f.imm), 32'h1234);
        check("ldm.pc_out", 32'(f.pc_out), 32'h4);
        check("ldm.next", 32'(f.imem_addr), 32'h6);

        step(1, 0, 0, 0, "br.bubble");
        step(1, 1, 1, 16'h0040, "br.redirect");
        check("br.valid", 32'(f.valid), 32'h0);
        check("br.addr", 32'(f.imem_addr), 32'h40);
        step(1, 0, 0, 0, "br.target");
        check("br.instr", 32'(f.instruction), 32'h0100);

        mem[0] = 16'h00FF;
        step(1, 0, 1, 16'hFFFF, "wrap.br");
        step(1, 0, 0, 0, "wrap.bubble");
        step(1, 0, 0, 0, "wrap.done");
        check("wrap.imm", 32'(f.imm), 32'h00FF);
        check("wrap.pc_out", 32'(f.pc_out), 32'hFFFF);
        check("wrap.next", 32'(f.imem_addr), 32'h1);
        step(0, 0, 1, 16'h1234, "en.off0");
        step(0, 1, 0, 0, "en.off1");
        check("en.instr", 32'(f.instruction), 32'hA5A5);
        check("en.addr", 32'(f.imem_addr), 32'h1);

        step(1, 0, 1, 16'h0004, "arst.br");
        step(1, 0, 0, 0, "arst.bubble");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("arst.now");
        @(negedge clk);
        rst = 1'b1;
        check_all("arst.hold");
        step(1, 0, 0, 0, "arst.restart");
        check("arst.pc_out", 32'(f.pc_out), 32'h0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7) != 0, $urandom_range(3) == 0,
                 $urandom_range(9) == 0, 16'($urandom_range(64)),
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
